program_loader: RTL and testbench

Boot-time instruction-memory writer for the single-cycle MIPS core: the write-side counterpart of the processor's instruction fetch path. It receives a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them into consecutive instruction-memory locations. It holds the CPU in clear until a complete frame with a correct checksum has been written. It sits beside the core at top level and drives the instruction memory's write port and the core's `clr`.

---
 rtl/program_loader.sv | 129 ++++++++++++
 tb/tb_program_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time instruction-memory writer: receives a framed, checksummed byte stream
// and writes big-endian 32-bit words to consecutive addresses while holding the CPU in clear.
module program_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_BYTES,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] words_left;
  logic [1:0]       byte_cnt;
  logic [7:0]       csum;
  logic             accept;

  assign accept = rx_valid && rx_ready;

  // Bytes shift straight into mem_data; after four shifts it holds the complete word.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= S_IDLE;
      words_left <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      rx_ready   <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= ADDR_W'(BASE_ADDR);
      mem_data   <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      mem_wen <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_COUNT;
            rx_ready <= 1'b1;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
          end
        end
        S_COUNT: begin
          if (accept) begin
            // A count byte of zero encodes a full 256-word frame.
            words_left <= {rx_data == 8'd0, rx_data};
            csum       <= rx_data;
            mem_addr   <= ADDR_W'(BASE_ADDR);
            byte_cnt   <= 2'd0;
            state      <= S_BYTES;
          end
        end
        S_BYTES: begin
          if (accept) begin
            mem_data <= {mem_data[23:0], rx_data};
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= S_WRITE;
              rx_ready <= 1'b0;
              mem_wen  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          mem_addr   <= mem_addr + ADDR_W'(1);
          words_left <= words_left - CNT_W'(1);
          rx_ready   <= 1'b1;
          state      <= (words_left == CNT_W'(1)) ? S_CSUM : S_BYTES;
        end
        S_CSUM: begin
          if (accept) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if (rx_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_ERROR: begin
          if (start) begin
            state    <= S_COUNT;
            error    <= 1'b0;
            rx_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: two instances (base 0x00 and 0x10) share one
// byte stream; a queue-based model predicts the written words, addresses and outcome.
module tb_program_loader;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned BASE0  = 0;
  localparam int unsigned BASE1  = 16;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;

  logic              rx_ready0, mem_wen0, cpu_hold0, busy0, done0, error0;
  logic [ADDR_W-1:0] mem_addr0;
  logic [31:0]       mem_data0;
  logic              rx_ready1, mem_wen1, cpu_hold1, busy1, done1, error1;
  logic [ADDR_W-1:0] mem_addr1;
  logic [31:0]       mem_data1;

  program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE0)) u_dut0 (
    .clk(clk), .clr(clr), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready0), .mem_wen(mem_wen0), .mem_addr(mem_addr0), .mem_data(mem_data0),
    .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .error(error0)
  );

  program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE1)) u_dut1 (
    .clk(clk), .clr(clr), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready1), .mem_wen(mem_wen1), .mem_addr(mem_addr1), .mem_data(mem_data1),
    .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .error(error1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int ready_viol = 0;

  logic [39:0] obs0[$];
  logic [39:0] obs1[$];

  logic [31:0] words[256];
  int          nwords;
  logic [7:0]  frame_csum;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe writes and done pulses away from the active edge.
  always @(negedge clk) begin
    if (mem_wen0) begin
      obs0.push_back({mem_addr0, mem_data0});
      if (rx_ready0) ready_viol++;
    end
    if (mem_wen1) obs1.push_back({mem_addr1, mem_data1});
    if (done0) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Model: word i of the frame lands at (base + i) mod 256 in both instances.
  function automatic int count_bad_writes(input int nw);
    int m = 0;
    logic [39:0] exp0, exp1;
    if (obs0.size() != nw) m++;
    if (obs1.size() != nw) m++;
    for (int i = 0; i < nw; i++) begin
      exp0 = {8'(BASE0 + i), words[i]};
      exp1 = {8'(BASE1 + i), words[i]};
      if (i >= obs0.size() || obs0[i] !== exp0) m++;
      if (i >= obs1.size() || obs1[i] !== exp1) m++;
    end
    return m;
  endfunction

  task automatic build_frame(input int nw, input bit fixed_word);
    nwords = nw;
    frame_csum = 8'(nw);
    for (int i = 0; i < nw; i++) begin
      words[i] = fixed_word ? 32'h2008_0005 : $urandom;
      for (int b = 0; b < 4; b++) frame_csum = frame_csum ^ words[i][8*(3-b) +: 8];
    end
  endtask

  task automatic clear_obs();
    obs0.delete();
    obs1.delete();
    done_cnt = 0;
    ready_viol = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int t;
    rx_valid = 1'b0;
    repeat (stall) @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    t = 0;
    while (!rx_ready0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready0) begin
      checks++;
      errors++;
      $display("FAIL handshake: rx_ready=%0b after 20 cycles, required 1", rx_ready0);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit bad, input int smin, input int smax, input bit poke);
    send_byte(8'(nwords), $urandom_range(smax, smin));
    for (int i = 0; i < nwords; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (poke && i == 0 && b == 1) start = 1'b1;
        send_byte(words[i][8*(3-b) +: 8], $urandom_range(smax, smin));
        start = 1'b0;
      end
    end
    send_byte(bad ? (frame_csum ^ 8'h01) : frame_csum, $urandom_range(smax, smin));
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (rx_ready0 !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %0b want 0", rx_ready0); end
    checks++; if (mem_wen0 !== 1'b0) begin errors++; $display("FAIL reset_mem_wen: got %0b want 0", mem_wen0); end
    checks++; if (mem_addr0 !== 8'h00) begin errors++; $display("FAIL reset_addr0: got %h want 00", mem_addr0); end
    checks++; if (mem_addr1 !== 8'h10) begin errors++; $display("FAIL reset_addr1: got %h want 10", mem_addr1); end
    checks++; if (mem_data0 !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", mem_data0); end
    checks++; if ({cpu_hold0, busy0, done0, error0} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: hold/busy/done/error got %b want 0000", {cpu_hold0, busy0, done0, error0});
    end
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    clear_obs();
    build_frame(1, 1'b1);
    pulse_start();
    checks++; if (cpu_hold0 !== 1'b1 || busy0 !== 1'b1) begin
      errors++; $display("FAIL single_hold_rise: hold=%0b busy=%0b want 1 1", cpu_hold0, busy0);
    end
    send_frame(1'b0, 0, 0, 1'b0);
    checks++; if (count_bad_writes(1) !== 0) begin errors++; $display("FAIL single_writes: %0d bad, want 0", count_bad_writes(1)); end
    checks++; if (obs0.size() > 0 && obs0[0] !== 40'h00_2008_0005) begin
      errors++; $display("FAIL single_word: got %h want 0020080005", obs0[0]);
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_cyc - start_cyc !== 8) begin errors++; $display("FAIL single_latency: got %0d want 8", done_cyc - start_cyc); end
    checks++; if (cpu_hold0 !== 1'b0 || error0 !== 1'b0) begin
      errors++; $display("FAIL single_end: hold=%0b error=%0b want 0 0", cpu_hold0, error0);
    end
  endtask

  task automatic test_stalls();
    clear_obs();
    build_frame(2, 1'b0);
    pulse_start();
    send_frame(1'b0, 3, 3, 1'b0);
    checks++; if (count_bad_writes(2) !== 0) begin errors++; $display("FAIL stall_writes: %0d bad, want 0", count_bad_writes(2)); end
    checks++; if (ready_viol !== 0) begin errors++; $display("FAIL stall_ready_in_write: got %0d want 0", ready_viol); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_bad_csum();
    clear_obs();
    build_frame(1, 1'b1);
    pulse_start();
    send_frame(1'b1, 0, 1, 1'b0);
    checks++; if (count_bad_writes(1) !== 0) begin errors++; $display("FAIL badcs_writes: %0d bad, want 0", count_bad_writes(1)); end
    checks++; if (error0 !== 1'b1 || cpu_hold0 !== 1'b1) begin
      errors++; $display("FAIL badcs_flags: error=%0b hold=%0b want 1 1", error0, cpu_hold0);
    end
    checks++; if (done_cnt !== 0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL badcs_done: done_cnt=%0d busy=%0b want 0 0", done_cnt, busy0);
    end
    pulse_start();
    checks++; if (error0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL badcs_restart: error=%0b busy=%0b want 0 1", error0, busy0);
    end
    clear_obs();
    build_frame(3, 1'b0);
    send_frame(1'b0, 0, 1, 1'b0);
    checks++; if (count_bad_writes(3) !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL badcs_recover: bad=%0d done=%0d want 0 1", count_bad_writes(3), done_cnt);
    end
  endtask

  task automatic test_full_frame();
    clear_obs();
    build_frame(256, 1'b0);
    pulse_start();
    send_frame(1'b0, 0, 0, 1'b0);
    checks++; if (count_bad_writes(256) !== 0) begin errors++; $display("FAIL full_writes: %0d bad, want 0", count_bad_writes(256)); end
    checks++; if (obs0.size() != 256 || obs0[255][39:32] !== 8'hFF) begin
      errors++; $display("FAIL full_last0: size=%0d want 256, last addr FF", obs0.size());
    end
    checks++; if (obs1.size() != 256 || obs1[255][39:32] !== 8'h0F) begin
      errors++; $display("FAIL full_last1: size=%0d want 256, last addr 0F", obs1.size());
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_clr_mid();
    clear_obs();
    build_frame(4, 1'b0);
    pulse_start();
    send_byte(8'd4, 0);
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) send_byte(words[i][8*(3-b) +: 8], 0);
    send_byte(words[2][31:24], 0);
    send_byte(words[2][23:16], 0);
    #2 clr = 1'b1;
    #1;
    checks++; if (rx_ready0 !== 1'b0 || mem_wen0 !== 1'b0) begin
      errors++; $display("FAIL clr_handshake: ready=%0b wen=%0b want 0 0", rx_ready0, mem_wen0);
    end
    checks++; if (mem_addr0 !== 8'h00 || mem_addr1 !== 8'h10 || mem_data0 !== 32'h0) begin
      errors++; $display("FAIL clr_bus: addr0=%h addr1=%h data=%h want 00 10 0", mem_addr0, mem_addr1, mem_data0);
    end
    checks++; if ({cpu_hold0, busy0, done0, error0} !== 4'b0000) begin
      errors++; $display("FAIL clr_flags: got %b want 0000", {cpu_hold0, busy0, done0, error0});
    end
    checks++; if (obs0.size() != 2 || obs0[0] !== {8'h00, words[0]} || obs0[1] !== {8'h01, words[1]}) begin
      errors++; $display("FAIL clr_partial: %0d writes before clr, want 2 matching words", obs0.size());
    end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clear_obs();
    build_frame(2, 1'b0);
    pulse_start();
    send_frame(1'b0, 0, 1, 1'b0);
    checks++; if (count_bad_writes(2) !== 0 || done_cnt !== 1) begin
      errors++; $display("FAIL clr_next_session: bad=%0d done=%0d want 0 1", count_bad_writes(2), done_cnt);
    end
  endtask

  task automatic test_start_ignored();
    clear_obs();
    build_frame(3, 1'b0);
    pulse_start();
    send_frame(1'b0, 0, 2, 1'b1);
    checks++; if (count_bad_writes(3) !== 0) begin errors++; $display("FAIL poke_writes: %0d bad, want 0", count_bad_writes(3)); end
    checks++; if (done_cnt !== 1 || error0 !== 1'b0) begin
      errors++; $display("FAIL poke_done: done=%0d error=%0b want 1 0", done_cnt, error0);
    end
  endtask

  task automatic test_random();
    bit bad;
    int n;
    for (int it = 0; it < 6; it++) begin
      clear_obs();
      n = $urandom_range(12, 1);
      bad = ($urandom_range(3, 0) == 0);
      build_frame(n, 1'b0);
      pulse_start();
      send_frame(bad, 0, 2, 1'b0);
      checks++; if (count_bad_writes(n) !== 0) begin errors++; $display("FAIL rand%0d_writes: %0d bad, want 0", it, count_bad_writes(n)); end
      checks++; if (done_cnt !== (bad ? 0 : 1) || error0 !== bad || cpu_hold0 !== bad) begin
        errors++; $display("FAIL rand%0d_outcome: done=%0d error=%0b hold=%0b want %0d %0b %0b",
                           it, done_cnt, error0, cpu_hold0, bad ? 0 : 1, bad, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stalls();
    test_bad_csum();
    test_full_frame();
    test_clr_mid();
    test_start_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
